// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage pipelined IEEE-754 single -> signed IW-bit integer
// converter with selectable rounding, saturation and NaN/Inf handling.
// Stage 1 aligns the magnitude and extracts guard/sticky; stage 2 rounds,
// range-checks, applies the sign and drives the registered outputs.
// Optional feature macro: FTOI_INEXACT_EN (drives out_inx; tied 0 otherwise).
module ftoi_pipe #(
  parameter int IW   = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [1:0]      in_rm,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_y,
  output logic            out_ovf,
  output logic [TAGW-1:0] out_tag,
  output logic            out_inx
);

  // Magnitude carries one extra bit so values up to 2^(IW+1)-1 fit.
  localparam int MW = IW + 1;
  // Biased exponents above this give a magnitude >= 2^(IW+1): always saturate.
  localparam logic [7:0]    E_BIG  = 8'(127 + IW);
  localparam logic [IW+1:0] HALF_W = {2'b00, 1'b1, {(IW-1){1'b0}}};
  localparam logic [IW+1:0] MAXP_W = HALF_W - {{(IW+1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] Y_MAX  = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] Y_MIN  = {1'b1, {(IW-1){1'b0}}};

  // Handshake: each stage advances when it is empty or its successor moves.
  logic adv1_s, adv2_s;
  logic v1_q, v1_d, v2_q, v2_d;

  assign adv2_s   = ~v2_q | out_ready;
  assign adv1_s   = ~v1_q | adv2_s;
  assign in_ready = adv1_s;

  // ---------------- Stage 1: decode and align ----------------
  logic            x_sign_s;
  logic [7:0]      x_exp_s;
  logic [22:0]     x_man_s;
  logic [23:0]     m1_s;
  logic [7:0]      rsh_s, lsh_s;
  logic [47:0]     rgt_s;
  logic [MW-1:0]   lft_s;

  assign x_sign_s = in_x[31];
  assign x_exp_s  = in_x[30:23];
  assign x_man_s  = in_x[22:0];
  assign m1_s     = {(x_exp_s != 8'd0), x_man_s};
  // Right shift for 0 <= E <= 23: integer in [47:24], guard [23], sticky [22:0].
  assign rsh_s    = 8'd150 - x_exp_s;
  assign rgt_s    = {m1_s, 24'd0} >> rsh_s;
  // Left shift for E > 23; only used when the result still fits in MW bits.
  assign lsh_s    = x_exp_s - 8'd150;
  assign lft_s    = MW'({32'd0, m1_s} << lsh_s);

  logic [MW-1:0] dec_mag_s;
  logic          dec_grd_s, dec_stk_s, dec_nan_s, dec_sat_s;

  // Classify the input and form aligned magnitude, guard and sticky.
  always_comb begin
    dec_mag_s = {MW{1'b0}};
    dec_grd_s = 1'b0;
    dec_stk_s = 1'b0;
    dec_nan_s = 1'b0;
    dec_sat_s = 1'b0;
    if (x_exp_s == 8'hFF) begin
      dec_nan_s = (x_man_s != 23'd0);
      dec_sat_s = (x_man_s == 23'd0);
    end else if (x_exp_s == 8'd0) begin
      // Zero and denormals flush to zero with no inexact contribution.
      dec_mag_s = {MW{1'b0}};
    end else if (x_exp_s > E_BIG) begin
      dec_sat_s = 1'b1;
    end else if (x_exp_s < 8'd126) begin
      dec_stk_s = 1'b1;
    end else if (x_exp_s == 8'd126) begin
      dec_grd_s = 1'b1;
      dec_stk_s = |x_man_s;
    end else if (x_exp_s <= 8'd150) begin
      dec_mag_s = MW'(rgt_s[47:24]);
      dec_grd_s = rgt_s[23];
      dec_stk_s = |rgt_s[22:0];
    end else begin
      dec_mag_s = lft_s;
    end
  end

  logic            s1_sign_q, s1_sign_d;
  logic [1:0]      s1_rm_q, s1_rm_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic [MW-1:0]   s1_mag_q, s1_mag_d;
  logic            s1_grd_q, s1_grd_d;
  logic            s1_stk_q, s1_stk_d;
  logic            s1_nan_q, s1_nan_d;
  logic            s1_sat_q, s1_sat_d;

  // Stage 1 next state: load a new op on accept, otherwise hold.
  always_comb begin
    v1_d      = v1_q;
    s1_sign_d = s1_sign_q;
    s1_rm_d   = s1_rm_q;
    s1_tag_d  = s1_tag_q;
    s1_mag_d  = s1_mag_q;
    s1_grd_d  = s1_grd_q;
    s1_stk_d  = s1_stk_q;
    s1_nan_d  = s1_nan_q;
    s1_sat_d  = s1_sat_q;
    if (adv1_s) begin
      v1_d = in_valid;
    end else begin
      v1_d = v1_q;
    end
    if (adv1_s & in_valid) begin
      s1_sign_d = x_sign_s;
      s1_rm_d   = in_rm;
      s1_tag_d  = in_tag;
      s1_mag_d  = dec_mag_s;
      s1_grd_d  = dec_grd_s;
      s1_stk_d  = dec_stk_s;
      s1_nan_d  = dec_nan_s;
      s1_sat_d  = dec_sat_s;
    end else begin
      s1_sign_d = s1_sign_q;
    end
  end

  // Stage 1 registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_rm_q   <= 2'd0;
      s1_tag_q  <= {TAGW{1'b0}};
      s1_mag_q  <= {MW{1'b0}};
      s1_grd_q  <= 1'b0;
      s1_stk_q  <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_sat_q  <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      s1_sign_q <= s1_sign_d;
      s1_rm_q   <= s1_rm_d;
      s1_tag_q  <= s1_tag_d;
      s1_mag_q  <= s1_mag_d;
      s1_grd_q  <= s1_grd_d;
      s1_stk_q  <= s1_stk_d;
      s1_nan_q  <= s1_nan_d;
      s1_sat_q  <= s1_sat_d;
    end
  end

  // ---------------- Stage 2: round, range-check, sign ----------------
  logic            inc_s;
  logic [IW+1:0]   rmag_s;
  logic [IW-1:0]   neg_s;
  logic [IW-1:0]   res_y_s;
  logic            res_ovf_s;

  // Magnitude increment decision for the selected rounding mode.
  always_comb begin
    inc_s = 1'b0;
    case (s1_rm_q)
      2'd0:    inc_s = s1_grd_q;
      2'd1:    inc_s = 1'b0;
      2'd2:    inc_s = s1_sign_q & (s1_grd_q | s1_stk_q);
      2'd3:    inc_s = ~s1_sign_q & (s1_grd_q | s1_stk_q);
      default: inc_s = 1'b0;
    endcase
  end

  assign rmag_s = {1'b0, s1_mag_q} + {{(IW+1){1'b0}}, inc_s};
  assign neg_s  = {IW{1'b0}} - rmag_s[IW-1:0];

  // Saturate or sign the rounded magnitude; -2^(IW-1) itself is in range.
  always_comb begin
    res_y_s   = Y_MAX;
    res_ovf_s = 1'b1;
    if (s1_nan_q) begin
      res_y_s   = Y_MAX;
      res_ovf_s = 1'b1;
    end else if (s1_sat_q) begin
      res_y_s   = s1_sign_q ? Y_MIN : Y_MAX;
      res_ovf_s = 1'b1;
    end else if (!s1_sign_q) begin
      if (rmag_s > MAXP_W) begin
        res_y_s   = Y_MAX;
        res_ovf_s = 1'b1;
      end else begin
        res_y_s   = rmag_s[IW-1:0];
        res_ovf_s = 1'b0;
      end
    end else begin
      if (rmag_s > HALF_W) begin
        res_y_s   = Y_MIN;
        res_ovf_s = 1'b1;
      end else begin
        res_y_s   = neg_s;
        res_ovf_s = 1'b0;
      end
    end
  end

  logic            y_ovf_q, y_ovf_d;
  logic [IW-1:0]   y_q, y_d;
  logic [TAGW-1:0] tag_q, tag_d;

  // Output stage next state: capture stage 1 on advance, hold under stall.
  always_comb begin
    v2_d    = v2_q;
    y_d     = y_q;
    y_ovf_d = y_ovf_q;
    tag_d   = tag_q;
    if (adv2_s) begin
      v2_d = v1_q;
    end else begin
      v2_d = v2_q;
    end
    if (adv2_s & v1_q) begin
      y_d     = res_y_s;
      y_ovf_d = res_ovf_s;
      tag_d   = s1_tag_q;
    end else begin
      y_d = y_q;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      y_q     <= {IW{1'b0}};
      y_ovf_q <= 1'b0;
      tag_q   <= {TAGW{1'b0}};
    end else begin
      v2_q    <= v2_d;
      y_q     <= y_d;
      y_ovf_q <= y_ovf_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = v2_q;
  assign out_y     = y_q;
  assign out_ovf   = y_ovf_q;
  assign out_tag   = tag_q;

`ifdef FTOI_INEXACT_EN
  logic inx_q, inx_d;

  // Inexact flag: nonzero discarded fraction, suppressed on saturation.
  always_comb begin
    inx_d = inx_q;
    if (adv2_s & v1_q) begin
      inx_d = (s1_grd_q | s1_stk_q) & ~res_ovf_s;
    end else begin
      inx_d = inx_q;
    end
  end

  // Inexact register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      inx_q <= 1'b0;
    end else begin
      inx_q <= inx_d;
    end
  end

  assign out_inx = inx_q;
`else
  assign out_inx = 1'b0;
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: a 32-bit and a 16-bit instance share one stimulus
// stream; expected results are queued on accept and compared on retire.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_x = 32'd0;
  logic [1:0]  in_rm = 2'd0;
  logic [4:0]  in_tag = 5'd0;

  logic        rdy32, ov32, ovf32, inx32;
  logic [31:0] y32;
  logic [4:0]  otag32;
  logic        rdy16, ov16, ovf16, inx16;
  logic [15:0] y16;
  logic [4:0]  otag16;

  int total = 0;
  int bad = 0;
  logic [62:0] sb[$];

  typedef struct packed {
    logic [1:0]  rm;
    logic [31:0] x;
    logic [31:0] y;
    logic        ovf;
    logic        inx;
  } vec_t;

  vec_t v32 [11];
  vec_t v16 [3];

  ftoi_pipe #(.IW(32), .TAGW(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_x(in_x),
    .in_rm(in_rm), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_y(y32), .out_ovf(ovf32), .out_tag(otag32), .out_inx(inx32)
  );

  ftoi_pipe #(.IW(16), .TAGW(5)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_x(in_x),
    .in_rm(in_rm), .in_tag(in_tag), .out_valid(ov16), .out_ready(out_ready),
    .out_y(y16), .out_ovf(ovf16), .out_tag(otag16), .out_inx(inx16)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: returns {y[31:0] (low iw bits meaningful), ovf, inx}.
  function automatic logic [33:0] ref_conv(input logic [31:0] x, input logic [1:0] rm, input int iw);
    longint maxv, minv, mag, rem, half, v;
    int k, e;
    logic s;
    bit up;
    s = x[31];
    e = int'(x[30:23]);
    maxv = (longint'(1) << (iw - 1)) - 1;
    minv = -(longint'(1) << (iw - 1));
    if (e == 255 && x[22:0] != 23'd0) return {32'(maxv), 1'b1, 1'b0};
    if (e == 255 || e > 180) return {(s ? 32'(minv) : 32'(maxv)), 1'b1, 1'b0};
    if (e == 0) return 34'd0;
    k = 150 - e;
    if (k <= 0) begin
      mag = longint'({1'b1, x[22:0]}) << (-k);
      rem = 0;
      half = 1;
    end else if (k > 24) begin
      mag = 0;
      rem = 1;
      half = 2;
    end else begin
      mag = longint'({1'b1, x[22:0]}) >> k;
      rem = longint'({1'b1, x[22:0]}) - (mag << k);
      half = longint'(1) << (k - 1);
    end
    case (rm)
      2'd0: up = (rem >= half);
      2'd1: up = 1'b0;
      2'd2: up = s && (rem != 0);
      default: up = !s && (rem != 0);
    endcase
    if (up) mag = mag + 1;
    v = s ? -mag : mag;
    if (v > maxv) return {32'(maxv), 1'b1, 1'b0};
    if (v < minv) return {32'(minv), 1'b1, 1'b0};
    return {32'(v), 1'b0, (rem != 0)};
  endfunction

  // Drive one cycle of stimulus; push the expected entry when the op is accepted.
  task automatic drive_cycle(input logic v, input logic [31:0] x, input logic [1:0] rm,
                             input logic [4:0] tag, input logic ordy,
                             input logic [33:0] e32, input logic [33:0] e16,
                             output logic acc, output logic ret, output logic [62:0] obs);
    logic ix32, ix16;
    @(negedge clk);
    in_valid = v;
    in_x = x;
    in_rm = rm;
    in_tag = tag;
    out_ready = ordy;
    #1;
    acc = v & rdy32;
    ret = ov32 & ordy;
    obs = {y32, ovf32, inx32, otag32, ov16, y16, ovf16, inx16, otag16};
`ifdef FTOI_INEXACT_EN
    ix32 = e32[0];
    ix16 = e16[0];
`else
    ix32 = 1'b0;
    ix16 = 1'b0;
`endif
    if (acc) sb.push_back({e32[33:1], ix32, tag, 1'b1, e16[17:1], ix16, tag});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ov32, ov16} !== 2'b00) begin
      bad++; $display("FAIL reset_valid got=%b exp=00", {ov32, ov16});
    end
    total++;
    if ({y32, ovf32, otag32, inx32} !== 39'd0) begin
      bad++; $display("FAIL reset_out32 got=%h exp=0", {y32, ovf32, otag32, inx32});
    end
    total++;
    if ({y16, ovf16, otag16, inx16} !== 23'd0) begin
      bad++; $display("FAIL reset_out16 got=%h exp=0", {y16, ovf16, otag16, inx16});
    end
    total++;
    if ({rdy32, rdy16} !== 2'b11) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=11", {rdy32, rdy16});
    end
  endtask

  task automatic test_vectors32();
    logic acc, ret;
    logic [62:0] obs, exp_v;
    int sent, idx;
    v32 = '{
      '{2'd0, 32'h40200000, 32'h00000003, 1'b0, 1'b1},
      '{2'd0, 32'hC0200000, 32'hFFFFFFFD, 1'b0, 1'b1},
      '{2'd0, 32'h3F000000, 32'h00000001, 1'b0, 1'b1},
      '{2'd1, 32'hC02CCCCD, 32'hFFFFFFFE, 1'b0, 1'b1},
      '{2'd2, 32'hBF000000, 32'hFFFFFFFF, 1'b0, 1'b1},
      '{2'd3, 32'h3DCCCCCD, 32'h00000001, 1'b0, 1'b1},
      '{2'd2, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
      '{2'd0, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{2'd0, 32'hCF000000, 32'h80000000, 1'b0, 1'b0},
      '{2'd0, 32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{2'd0, 32'hFF800000, 32'h80000000, 1'b1, 1'b0}
    };
    sent = 0;
    for (int c = 0; c < 60 && (sent < 11 || sb.size() != 0); c++) begin
      idx = (sent < 11) ? sent : 10;
      drive_cycle(sent < 11, v32[idx].x, v32[idx].rm, 5'(idx), 1'b1,
                  {v32[idx].y, v32[idx].ovf, v32[idx].inx},
                  ref_conv(v32[idx].x, v32[idx].rm, 16), acc, ret, obs);
      if (acc) sent++;
      if (ret) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL vec32 unexpected result got=%h exp=none", obs);
        end else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin bad++; $display("FAIL vec32 got=%h exp=%h", obs, exp_v); end
        end
      end
    end
    total++;
    if (sent != 11 || sb.size() != 0) begin
      bad++; $display("FAIL vec32_done sent=%0d pending=%0d exp sent=11 pending=0", sent, sb.size());
    end
  endtask

  task automatic test_iw16();
    logic acc, ret;
    logic [62:0] obs, exp_v;
    int sent, idx;
    v16 = '{
      '{2'd0, 32'h46FFFE00, 32'h00007FFF, 1'b0, 1'b0},
      '{2'd0, 32'h46FFFF00, 32'h00007FFF, 1'b1, 1'b0},
      '{2'd0, 32'hC7000000, 32'h00008000, 1'b0, 1'b0}
    };
    sent = 0;
    for (int c = 0; c < 30 && (sent < 3 || sb.size() != 0); c++) begin
      idx = (sent < 3) ? sent : 2;
      drive_cycle(sent < 3, v16[idx].x, v16[idx].rm, 5'(idx + 16), 1'b1,
                  ref_conv(v16[idx].x, v16[idx].rm, 32),
                  {16'd0, v16[idx].y[15:0], v16[idx].ovf, v16[idx].inx}, acc, ret, obs);
      if (acc) sent++;
      if (ret) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL iw16 unexpected result got=%h exp=none", obs);
        end else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin bad++; $display("FAIL iw16 got=%h exp=%h", obs, exp_v); end
        end
      end
    end
    total++;
    if (sent != 3 || sb.size() != 0) begin
      bad++; $display("FAIL iw16_done sent=%0d pending=%0d exp sent=3 pending=0", sent, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic acc, ret, ordy;
    logic [62:0] obs, exp_v;
    logic [31:0] x;
    int sent;
    sent = 0;
    for (int c = 0; c < 60 && (sent < 6 || sb.size() != 0); c++) begin
      ordy = !(c >= 3 && c <= 6);
      x = {sent[0], 8'(127 + sent), 23'h2AAAAA};
      drive_cycle(sent < 6, x, 2'd0, 5'(sent), ordy,
                  ref_conv(x, 2'd0, 32), ref_conv(x, 2'd0, 16), acc, ret, obs);
      if (acc) sent++;
      if (c >= 3 && c <= 6) begin
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, acc); end
        total++;
        if (ov32 !== 1'b1 || sb.size() == 0 || obs !== sb[0]) begin
          bad++; $display("FAIL bp_hold cycle=%0d valid=%b got=%h exp=head of queue", c, ov32, obs);
        end
      end
      if (ret) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp unexpected result got=%h exp=none", obs);
        end else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin bad++; $display("FAIL bp got=%h exp=%h", obs, exp_v); end
        end
      end
    end
    total++;
    if (sent != 6 || sb.size() != 0) begin
      bad++; $display("FAIL bp_done sent=%0d pending=%0d exp sent=6 pending=0", sent, sb.size());
    end
  endtask

  task automatic test_random();
    logic acc, ret, ordy, v;
    logic [62:0] obs, exp_v;
    logic [31:0] x;
    logic [7:0] e;
    logic [1:0] rm;
    int sent;
    sent = 0;
    for (int c = 0; c < 600 && (sent < 60 || sb.size() != 0); c++) begin
      case ($urandom_range(0, 9))
        0: e = 8'd0;
        1: e = 8'd255;
        2: e = 8'($urandom_range(1, 125));
        default: e = 8'($urandom_range(120, 162));
      endcase
      x = {1'($urandom_range(0, 1)), e, 23'($urandom())};
      rm = 2'($urandom_range(0, 3));
      v = (sent < 60) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive_cycle(v, x, rm, 5'(sent), ordy, ref_conv(x, rm, 32), ref_conv(x, rm, 16), acc, ret, obs);
      if (acc) sent++;
      if (ret) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rand unexpected result got=%h exp=none", obs);
        end else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin bad++; $display("FAIL rand x=%h rm=%0d got=%h exp=%h", x, rm, obs, exp_v); end
        end
      end
    end
    total++;
    if (sent != 60 || sb.size() != 0) begin
      bad++; $display("FAIL rand_done sent=%0d pending=%0d exp sent=60 pending=0", sent, sb.size());
    end
  endtask

  task automatic test_reset_inflight();
    logic acc, ret;
    logic [62:0] obs, exp_v;
    drive_cycle(1'b1, 32'h3FC00000, 2'd0, 5'd1, 1'b1,
                ref_conv(32'h3FC00000, 2'd0, 32), ref_conv(32'h3FC00000, 2'd0, 16), acc, ret, obs);
    drive_cycle(1'b1, 32'h40400000, 2'd0, 5'd2, 1'b1,
                ref_conv(32'h40400000, 2'd0, 32), ref_conv(32'h40400000, 2'd0, 16), acc, ret, obs);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ov32, ov16} !== 2'b00) begin
      bad++; $display("FAIL rst_flight_valid got=%b exp=00", {ov32, ov16});
    end
    sb.delete();
    drive_cycle(1'b1, 32'h42F70000, 2'd0, 5'd7, 1'b1,
                ref_conv(32'h42F70000, 2'd0, 32), ref_conv(32'h42F70000, 2'd0, 16), acc, ret, obs);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL rst_flight_accept got=%b exp=1", acc); end
    drive_cycle(1'b0, 32'd0, 2'd0, 5'd0, 1'b1, 34'd0, 34'd0, acc, ret, obs);
    total++;
    if (ov32 !== 1'b0) begin bad++; $display("FAIL rst_flight_lat1 got=%b exp=0", ov32); end
    drive_cycle(1'b0, 32'd0, 2'd0, 5'd0, 1'b1, 34'd0, 34'd0, acc, ret, obs);
    total++;
    if (ov32 !== 1'b1) begin bad++; $display("FAIL rst_flight_lat2 got=%b exp=1", ov32); end
    if (ret) begin
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL rst_flight unexpected result got=%h exp=none", obs);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin bad++; $display("FAIL rst_flight got=%h exp=%h", obs, exp_v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors32();
    test_iw16();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
